// File: rtl/pipe_mux_tree_if.sv
// Handshake and data bundle for pipe_mux_tree: input side (valid/ready, word,
// per-lane selects) and output side (valid/ready, lane bits, occupancy).
interface pipe_mux_tree_if #(
  parameter int DATA_WIDTH = 256,
  parameter int SEL_WIDTH  = 8,
  parameter int LANES      = 4,
  parameter int LEVELS     = 2
);
  localparam int OCC_W = $clog2(LEVELS + 1);

  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_WIDTH-1:0]      a_in;
  logic [LANES*SEL_WIDTH-1:0] sel;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES-1:0]           y;
  logic [OCC_W-1:0]           occupancy;

  modport master (
    output in_valid, a_in, sel, out_ready,
    input  in_ready, out_valid, y, occupancy
  );

  modport slave (
    input  in_valid, a_in, sel, out_ready,
    output in_ready, out_valid, y, occupancy
  );
endinterface

// File: rtl/pipe_mux_tree.sv
// Pipelined RADIX-ary bit-select tree: each lane picks a_in[sel_L] through
// LEVELS registered levels, with a single global advance enable for backpressure.
module pipe_mux_tree #(
  parameter int DATA_WIDTH = 256,
  parameter int SEL_WIDTH  = 8,
  parameter int RADIX      = 16,
  parameter int LANES      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_mux_tree_if.slave  bus
);
  localparam int LOG2R  = $clog2(RADIX);
  localparam int LEVELS = SEL_WIDTH / LOG2R;
  localparam int OCC_W  = $clog2(LEVELS + 1);

  logic              w_adv;
  logic [LEVELS-1:0] w_valid_vec;
  logic [OCC_W-1:0]  w_occ;

  assign w_adv        = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  genvar gi, gl, gj;
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
      // Per lane, a stage carries {unused upper select bits, surviving candidates}.
      localparam int W_IN  = DATA_WIDTH >> (LOG2R * gi);
      localparam int W_OUT = W_IN >> LOG2R;
      localparam int S_IN  = SEL_WIDTH - LOG2R * gi;
      localparam int S_OUT = S_IN - LOG2R;
      localparam int C_IN  = W_IN + S_IN;
      localparam int C_OUT = W_OUT + S_OUT;

      logic [LANES*C_IN-1:0]  w_in;
      logic [LANES*C_OUT-1:0] w_out;
      logic                   w_vin;
      logic                   r_valid;
      logic [LANES*C_OUT-1:0] r_pay;

      if (gi == 0) begin : g_src
        for (gl = 0; gl < LANES; gl++) begin : g_lane
          assign w_in[gl*C_IN +: C_IN] = {bus.sel[gl*SEL_WIDTH +: SEL_WIDTH], bus.a_in};
        end
        assign w_vin = bus.in_valid;
      end else begin : g_src
        assign w_in  = g_lvl[gi-1].r_pay;
        assign w_vin = g_lvl[gi-1].r_valid;
      end

      for (gl = 0; gl < LANES; gl++) begin : g_lane
        logic [LOG2R-1:0] w_idx;
        assign w_idx = w_in[gl*C_IN + W_IN +: LOG2R];

        for (gj = 0; gj < W_OUT; gj++) begin : g_bit
          logic [RADIX-1:0] w_grp;
          assign w_grp                  = w_in[gl*C_IN + gj*RADIX +: RADIX];
          assign w_out[gl*C_OUT + gj]   = w_grp[w_idx];
        end

        if (S_OUT > 0) begin : g_rem
          assign w_out[gl*C_OUT + W_OUT +: S_OUT] = w_in[gl*C_IN + W_IN + LOG2R +: S_OUT];
        end
      end

      // Bubbles shift too, so a stage always mirrors its predecessor when advancing.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_pay   <= '0;
        end else if (w_adv) begin
          r_valid <= w_vin;
          r_pay   <= w_out;
        end
      end

      assign w_valid_vec[gi] = r_valid;
    end
  endgenerate

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < LEVELS; k++) begin
      w_occ = w_occ + OCC_W'(w_valid_vec[k]);
    end
  end

  assign bus.occupancy = w_occ;
  assign bus.out_valid = g_lvl[LEVELS-1].r_valid;
  assign bus.y         = g_lvl[LEVELS-1].r_pay;
endmodule
